// File: rtl/lab_4_countdown_timer_pkg.sv
// Package for the countdown timer: state type and widths.
// Pulls the state encodings from the shared defs include.
package lab_4_countdown_timer_pkg;

`include "lab_4_timer_defs.vh"

    localparam int CNT_W = 4;

endpackage

// File: rtl/lab_4_prescaler.sv
// Prescaler: counts 0..PRESCALE-1 while en, ticks on last.
// Ports: clk, rst (async high), en, clr (wins over en), tick.
module lab_4_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lab_4_timer_defs.vh
// Shared FSM state encodings for the countdown timer.
// Included by the timer package; visible to RTL and bench.
`ifndef LAB_4_TIMER_DEFS_VH
`define LAB_4_TIMER_DEFS_VH

typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
} state_e;

`endif

// File: rtl/lab_4_countdown_timer.sv
// 4-bit countdown timer with load/start/pause and done pulse.
// Ports: clk, rst, load, load_val, start, pause -> out, busy, done, state.
module lab_4_countdown_timer
    import lab_4_countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [CNT_W-1:0]      out,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic go;
    logic p_en;
    logic p_clr;
    logic tick;

    // pause outranks start, so a start only counts with pause low
    assign go = start && !pause;

    // prescaler frozen outside RUN and on a pause edge,
    // which also discards a coincident tick
    assign p_en = (state_q == RUN) && !load && !pause;

    assign p_clr = load
        || (go && (state_q == IDLE) && (out_q != '0))
        || (go && (state_q == DONE) && (reload_q != '0));

    lab_4_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (p_en),
        .clr  (p_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        if (out_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        // saturate at zero rather than wrap
                        if (out_q <= 4'd1) begin
                            out_d   = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            out_d = out_q - 4'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (go) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (go) begin
                        if (reload_q != '0) begin
                            out_d   = reload_q;
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign out   = out_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSED);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_lab_4_countdown_timer.sv
// Bench for lab_4_countdown_timer (PRESCALE=4): vector table
// plus hand-written reset-abort sequence, scoreboard queue.
module tb_lab_4_countdown_timer;
    import lab_4_countdown_timer_pkg::*;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic       ld;
        logic [3:0] val;
        logic       st;
        logic       pa;
        logic [3:0] e_out;
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_state;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] out;
        logic       busy;
        logic       done;
        logic [1:0] state;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    lab_4_countdown_timer #(
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int n, logic ld, logic [3:0] val,
                                logic st, logic pa, logic [3:0] eo,
                                logic eb, logic ed, logic [1:0] es);
        vec_t v;
        v.n = n; v.ld = ld; v.val = val; v.st = st; v.pa = pa;
        v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_state = es;
        return v;
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic expect_push(string tag, logic [3:0] o, logic b,
                               logic d, logic [1:0] s);
        exp_t e;
        e.tag = tag; e.out = o; e.busy = b; e.done = d; e.state = s;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue required entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".out"}, out, e.out);
        chk({e.tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
        chk({e.tag, ".done"}, {3'b0, done}, {3'b0, e.done});
        chk({e.tag, ".state"}, {2'b0, state}, {2'b0, e.state});
    endtask

    task automatic drive(logic ld, logic [3:0] val, logic st, logic pa);
        load = ld; load_val = val; start = st; pause = pa;
    endtask

    localparam logic [1:0] SI = 2'(IDLE);
    localparam logic [1:0] SR = 2'(RUN);
    localparam logic [1:0] SP = 2'(PAUSED);
    localparam logic [1:0] SD = 2'(DONE);

    initial begin
        // basic countdown from 3
        tbl.push_back(mk(1, 1, 3, 0, 0, 3, 0, 0, SI));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, SR));
        tbl.push_back(mk(3, 0, 0, 0, 0, 3, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, SR));
        tbl.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, SR));
        tbl.push_back(mk(3, 0, 0, 0, 0, 1, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, SD));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, SD));
        // restart from DONE repeats the countdown
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, SR));
        tbl.push_back(mk(4, 0, 0, 0, 0, 2, 1, 0, SR));
        tbl.push_back(mk(8, 0, 0, 0, 0, 0, 0, 1, SD));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, SD));
        // start held through RUN and DONE
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, SR));
        tbl.push_back(mk(12, 0, 0, 1, 0, 0, 0, 1, SD));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, SR));
        // pause for 10 cycles, resume
        tbl.push_back(mk(5, 0, 0, 0, 0, 2, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 1, 0, SP));
        tbl.push_back(mk(9, 0, 0, 0, 1, 2, 1, 0, SP));
        tbl.push_back(mk(1, 0, 0, 1, 0, 2, 1, 0, SR));
        tbl.push_back(mk(6, 0, 0, 0, 0, 1, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, SD));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, SD));
        // zero load, start from IDLE and DONE
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, SI));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, SD));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, SD));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, SD));
        // reload mid-run, load beats start
        tbl.push_back(mk(1, 1, 9, 0, 0, 9, 0, 0, SI));
        tbl.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, SI));
        tbl.push_back(mk(1, 0, 0, 1, 0, 9, 1, 0, SR));
        tbl.push_back(mk(8, 0, 0, 0, 0, 7, 1, 0, SR));
        tbl.push_back(mk(1, 1, 5, 1, 0, 5, 0, 0, SI));
        tbl.push_back(mk(4, 0, 0, 0, 0, 5, 0, 0, SI));
        // pause coincident with tick discards it
        tbl.push_back(mk(1, 0, 0, 1, 0, 5, 1, 0, SR));
        tbl.push_back(mk(3, 0, 0, 0, 0, 5, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5, 1, 0, SP));
        tbl.push_back(mk(1, 0, 0, 1, 0, 5, 1, 0, SR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, SR));

        rst = 1'b1;
        drive(0, 0, 0, 0);
        #3;
        expect_push("reset", 0, 0, 0, SI);
        compare_pop();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].pa);
            expect_push($sformatf("v%0d", i), tbl[i].e_out,
                        tbl[i].e_busy, tbl[i].e_done, tbl[i].e_state);
            repeat (tbl[i].n) @(posedge clk);
            #1;
            compare_pop();
        end

        // asynchronous reset during RUN at out=6
        @(negedge clk);
        drive(1, 9, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0);
        expect_push("pre_rst", 6, 1, 0, SR);
        repeat (12) @(posedge clk);
        #1;
        compare_pop();
        #1;
        rst = 1'b1;
        #1;
        expect_push("async_rst", 0, 0, 0, SI);
        compare_pop();
        #1;
        rst = 1'b0;
        expect_push("post_rst", 0, 0, 0, SI);
        @(posedge clk);
        #1;
        compare_pop();
        @(negedge clk);
        drive(0, 0, 1, 0);
        expect_push("rst_start", 0, 0, 1, SD);
        @(posedge clk);
        #1;
        compare_pop();
        drive(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/lab_4_countdown_timer.md
LAB_4_COUNTDOWN_TIMER -- requirements
Module: lab_4_countdown_timer

Interface
REQ-001 Parameter PRESCALE, default 4, SHALL set the clock cycles per count step (legal range 1..256).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its positive edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 load  input  1  SHALL request loading load_val into the count and reload registers.
REQ-005 load_val  input  4  SHALL carry the start value, 0..15.
REQ-006 start  input  1  SHALL request start or resume.
REQ-007 pause  input  1  SHALL request a pause of a running countdown.
REQ-008 out  output  4  SHALL carry the registered current count.
REQ-009 busy  output  1  SHALL be high exactly while state is RUN or PAUSED.
REQ-010 done  output  1  SHALL be a registered one-cycle pulse on reaching zero.
REQ-011 state  output  2  SHALL expose the FSM state: IDLE=0, RUN=1, PAUSED=2, DONE=3.

Function
REQ-012 The block SHALL be a 4-bit down counter, the complement of the lab 4 up counter; it SHALL never wrap below 0.
REQ-013 Input priority per edge SHALL be load > pause > start, in every state.
REQ-014 load SHALL, in any state: set out and reload to load_val, enter IDLE, clear the prescaler and force done low.
REQ-015 IDLE + start: out!=0 -> RUN with the prescaler cleared; out==0 -> DONE with done high for that cycle.
REQ-016 In RUN the prescaler SHALL count 0..PRESCALE-1 and assert tick when it holds PRESCALE-1, then wrap to 0.
REQ-017 On tick, out SHALL decrement by 1; with PRESCALE=4, the first decrement SHALL occur 4 edges after the edge that entered RUN.
REQ-018 A tick with out==1 SHALL make out 0, enter DONE and raise done on that same edge, for exactly one cycle.
REQ-019 RUN + pause SHALL enter PAUSED, freezing out and the prescaler value; a tick coincident with pause SHALL be discarded.
REQ-020 PAUSED + start (pause low) SHALL return to RUN, resuming the prescaler from its frozen value; otherwise the block SHALL stay PAUSED.
REQ-021 DONE + start SHALL copy reload into out, clear the prescaler and enter RUN; if reload==0 it SHALL stay DONE and pulse done again.
REQ-022 pause in IDLE or DONE SHALL have no effect.
REQ-023 start held high in RUN SHALL have no effect; start held high through DONE SHALL restart on every edge as per REQ-021.

Reset
REQ-024 rst high SHALL immediately, independent of clk, force out=0, reload=0, prescaler=0, state=IDLE, done=0, busy=0.
REQ-025 rst asserted mid-countdown SHALL abort it with no done pulse; the first edge after release SHALL obey REQ-013..023 from IDLE.

Structure
REQ-026 The state encodings (IDLE, RUN, PAUSED, DONE) SHALL live in the shared include lab_4_timer_defs.vh, used by RTL and bench.
REQ-027 The prescaler SHALL be the sub-module lab_4_prescaler, with ports clk, rst, en, clr and tick, and parameter PRESCALE.
REQ-028 busy SHALL be decoded from the state register; done SHALL be a flop.

Verification (PRESCALE=4)
REQ-029 load_val=3 with load, then start -> out is 3,2,1,0 at edges +4,+8,+12; done high only in the cycle after edge +12; state=3.
REQ-030 load 3, start, pause high at cycle 6 for 10 cycles, then start -> out frozen at 2; 0 is reached 12 RUN cycles after the start edge.
REQ-031 After REQ-029, start once -> out reloads 3, busy=1, and the countdown and done pulse repeat identically.
REQ-032 load_val=0 with load, then start -> DONE on the next edge, done high for one cycle, out stays 0.
REQ-033 load 9, start, then at out=7 assert load with load_val=5 -> state=IDLE, out=5, busy=0, no done pulse.
REQ-034 rst pulsed between clock edges during RUN at out=6 -> out=0 and state=0 before the next edge; no done pulse.
